lock_controller: RTL and testbench

- Sequencing FSM for the combination-lock datapath (16-bit entry shift register A, stored-code register B, Pass/Reverse comparators).
- Drives ShiftA, ShiftB and ResetA; consumes Pass and Reverse.
- Counts entered digits and applies the unlock, duress (reversed-code), failed-attempt lockout, auto-relock and code-change policy.
- Sits between the debounced keypad/button front end and the datapath; all outputs go to the datapath and the status LEDs.

---
 rtl/lock_controller.sv | 154 +++++++++++++++
 tb/tb_lock_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_controller.sv
`default_nettype none
// ============================================================================
// lock_controller : sequencing FSM for the combination-lock datapath
// Rev 1.0
// ============================================================================
module lock_controller #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned OPEN_CYCLES = 500000000,
  parameter int unsigned LOCK_CYCLES = 1000000000,
  parameter int unsigned TMR_W       = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       validate_i,
  input  logic       cancel_i,
  input  logic       lock_i,
  input  logic       change_code_i,
  input  logic       pass_i,
  input  logic       reverse_i,
  output logic       shift_a_o,
  output logic       shift_b_o,
  output logic       reset_a_o,
  output logic       unlocked_o,
  output logic       alarm_o,
  output logic       locked_out_o,
  output logic [2:0] digit_count_o,
  output logic [2:0] fail_count_o
);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_DURESS  = 3'd4,
    S_PROGRAM = 3'd5,
    S_LOCKOUT = 3'd6
  } state_e;

  localparam logic [2:0]       DIGIT_LAST = 3'(DIGITS - 1);
  localparam logic [2:0]       DIGIT_FULL = 3'(DIGITS);
  localparam logic [2:0]       FAIL_LAST  = 3'(MAX_FAIL - 1);
  localparam logic [2:0]       FAIL_MAX   = 3'(MAX_FAIL);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       digit_q, digit_d;
  logic [2:0]       fail_q,  fail_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_CLEAR;
      timer_q <= '0;
      digit_q <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      digit_q <= digit_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    digit_d = digit_q;
    fail_d  = fail_q;
    unique case (state_q)
      S_CLEAR: begin
        state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (cancel_i) begin
          state_d = S_CLEAR;
        end else if (validate_i) begin
          if (digit_q == DIGIT_LAST) begin
            digit_d = DIGIT_FULL;
            state_d = S_CHECK;
          end else begin
            digit_d = digit_q + 3'd1;
          end
        end
      end
      S_CHECK: begin
        if (pass_i) begin
          fail_d  = '0;
          state_d = S_OPEN;
        end else if (reverse_i) begin
          fail_d  = '0;
          state_d = S_DURESS;
        end else if (fail_q == FAIL_LAST) begin
          fail_d  = FAIL_MAX;
          state_d = S_LOCKOUT;
        end else begin
          fail_d  = fail_q + 3'd1;
          state_d = S_CLEAR;
        end
      end
      S_OPEN, S_DURESS: begin
        if (lock_i || (timer_q == OPEN_LAST)) begin
          state_d = S_CLEAR;
        end else if (change_code_i && (state_q == S_OPEN)) begin
          state_d = S_PROGRAM;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_PROGRAM: begin
        // Cancel/Lock deliberately not decoded: B must never be left half-written.
        if (validate_i) begin
          if (digit_q == DIGIT_LAST) begin
            state_d = S_CLEAR;
          end else begin
            digit_d = digit_q + 3'd1;
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          fail_d  = '0;
          state_d = S_CLEAR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    // Every state change restarts the timer and digit count; only CHECK keeps the full count.
    if (state_d != state_q) begin
      timer_d = '0;
      if (state_d != S_CHECK) begin
        digit_d = '0;
      end
    end
  end

  assign shift_a_o     = (state_q == S_ENTRY);
  assign shift_b_o     = (state_q == S_PROGRAM);
  assign reset_a_o     = (state_q == S_CLEAR);
  assign unlocked_o    = (state_q == S_OPEN) || (state_q == S_DURESS);
  assign alarm_o       = (state_q == S_DURESS);
  assign locked_out_o  = (state_q == S_LOCKOUT);
  assign digit_count_o = digit_q;
  assign fail_count_o  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_controller.sv
`default_nettype none
// ============================================================================
// tb_lock_controller : directed + random bench for lock_controller
// Rev 1.0
// ============================================================================
module tb_lock_controller;

  localparam int OPEN_C = 20;
  localparam int LOCK_C = 30;
  localparam int MAXF   = 3;

  localparam int P_CLEAR = 0, P_ENTRY = 1, P_CHECK = 2, P_OPEN = 3,
                 P_DURESS = 4, P_PROGRAM = 5, P_LOCKOUT = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       validate, cancel, lock, change_code;
  logic       shift_a, shift_b, reset_a, unlocked, alarm, locked_out;
  logic [2:0] digit_count, fail_count;
  logic       pass, rev;

  int         checks = 0;
  int         errors = 0;
  logic       cmp_en = 1'b0;

  int         m_phase, m_digits, m_fails, m_ticks;
  logic [15:0] mA, mB;

  assign pass = (mA == mB);
  assign rev  = (mA == {mB[3:0], mB[7:4], mB[11:8], mB[15:12]});

  lock_controller #(
    .DIGITS(4), .MAX_FAIL(MAXF), .OPEN_CYCLES(OPEN_C), .LOCK_CYCLES(LOCK_C), .TMR_W(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .validate_i(validate), .cancel_i(cancel), .lock_i(lock), .change_code_i(change_code),
    .pass_i(pass), .reverse_i(rev),
    .shift_a_o(shift_a), .shift_b_o(shift_b), .reset_a_o(reset_a),
    .unlocked_o(unlocked), .alarm_o(alarm), .locked_out_o(locked_out),
    .digit_count_o(digit_count), .fail_count_o(fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = P_CLEAR;
    m_digits = 0;
    m_fails  = 0;
    m_ticks  = 0;
    mA       = 16'h0000;
  endtask

  // One clock edge of the policy, plus the datapath registers the controller steers.
  task automatic model_step(input logic v, input logic c, input logic l,
                            input logic cc, input logic [3:0] d);
    int  p0, nxt;
    logic pm, rm;
    p0  = m_phase;
    nxt = m_phase;
    pm  = (mA == mB);
    rm  = (mA == {mB[3:0], mB[7:4], mB[11:8], mB[15:12]});
    case (p0)
      P_CLEAR: nxt = P_ENTRY;
      P_ENTRY: begin
        if (c) nxt = P_CLEAR;
        else if (v) begin
          m_digits++;
          if (m_digits == 4) nxt = P_CHECK;
        end
      end
      P_CHECK: begin
        if (pm)                     begin m_fails = 0;    nxt = P_OPEN;    end
        else if (rm)                begin m_fails = 0;    nxt = P_DURESS;  end
        else if (m_fails == MAXF-1) begin m_fails = MAXF; nxt = P_LOCKOUT; end
        else                        begin m_fails++;      nxt = P_CLEAR;   end
      end
      P_OPEN, P_DURESS: begin
        if (l || m_ticks == OPEN_C - 1) nxt = P_CLEAR;
        else if (cc && p0 == P_OPEN)    nxt = P_PROGRAM;
      end
      P_PROGRAM: begin
        if (v) begin
          m_digits++;
          if (m_digits == 4) nxt = P_CLEAR;
        end
      end
      P_LOCKOUT: begin
        if (m_ticks == LOCK_C - 1) begin m_fails = 0; nxt = P_CLEAR; end
      end
      default: nxt = P_CLEAR;
    endcase
    if (p0 == P_CLEAR)            mA = 16'h0000;
    else if (p0 == P_ENTRY && v)  mA = {mA[11:0], d};
    if (p0 == P_PROGRAM && v)     mB = {mB[11:0], d};
    if (nxt != p0) begin
      m_ticks = 0;
      if (nxt != P_CHECK) m_digits = 0;
    end else begin
      m_ticks++;
    end
    m_phase = nxt;
  endtask

  task automatic cycle(input logic v, input logic c, input logic l,
                       input logic cc, input logic [3:0] d);
    validate = v; cancel = c; lock = l; change_code = cc;
    @(posedge clk);
    #1;
    model_step(v, c, l, cc, d);
    @(negedge clk);
    validate = 1'b0; cancel = 1'b0; lock = 1'b0; change_code = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic wait_entry();
    int n;
    n = 0;
    while (m_phase != P_ENTRY && n < 200) begin
      idle(1);
      n++;
    end
    if (m_phase != P_ENTRY) begin
      checks++;
      errors++;
      $display("FAIL wait_entry: phase %0d after %0d cycles, required %0d", m_phase, n, P_ENTRY);
    end
  endtask

  task automatic enter(input logic [15:0] code);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, code[15-4*i -: 4]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [5:0] exp_f, act_f;
      logic       dig_ok;
      exp_f  = {m_phase == P_ENTRY, m_phase == P_PROGRAM, m_phase == P_CLEAR,
                (m_phase == P_OPEN) || (m_phase == P_DURESS), m_phase == P_DURESS,
                m_phase == P_LOCKOUT};
      act_f  = {shift_a, shift_b, reset_a, unlocked, alarm, locked_out};
      dig_ok = !(m_phase inside {P_ENTRY, P_CHECK, P_PROGRAM, P_LOCKOUT}) ||
               (int'(digit_count) == m_digits);
      checks++;
      if (act_f !== exp_f || int'(fail_count) != m_fails || !dig_ok) begin
        errors++;
        $display("FAIL cycle_compare t=%0t phase=%0d: flags got %b expected %b, fail got %0d expected %0d, digits got %0d expected %0d",
                 $time, m_phase, act_f, exp_f, fail_count, m_fails, digit_count, m_digits);
      end
    end
  end

  initial begin
    int n;
    int r;
    logic [3:0] d;
    rst_n = 1'b0;
    validate = 1'b0; cancel = 1'b0; lock = 1'b0; change_code = 1'b0;
    mB = 16'h1234;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_reseta",   reset_a,     1);
    chk("reset_unlocked", unlocked,    0);
    chk("reset_shifta",   shift_a,     0);
    chk("reset_digits",   digit_count, 0);
    chk("reset_fails",    fail_count,  0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // correct code, full open window
    wait_entry();
    enter(16'h1234);
    chk("check_digits", digit_count, 4);
    chk("check_shifta", shift_a, 0);
    idle(1);
    n = 0;
    while (unlocked && n < 100) begin n++; idle(1); end
    chk("open_len", n, OPEN_C);
    chk("relock_reseta", reset_a, 1);

    // duress
    wait_entry();
    enter(16'h4321);
    idle(1);
    chk("duress_alarm", alarm, 1);
    chk("duress_unlocked", unlocked, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    chk("duress_cc_ignored", alarm, 1);
    chk("duress_no_program", shift_b, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("duress_lock_alarm", alarm, 0);
    chk("duress_lock_clear", reset_a, 1);

    // three failures -> lockout
    for (int k = 1; k <= 3; k++) begin
      wait_entry();
      enter(16'h1111);
      idle(1);
      chk("fail_count_step", fail_count, k);
    end
    chk("lockout_active", locked_out, 1);
    n = 0;
    while (locked_out && n < 200) begin
      n++;
      if (n == 10) chk("lockout_digits", digit_count, 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
    end
    chk("lockout_len", n, LOCK_C);
    chk("lockout_fail_clr", fail_count, 0);
    wait_entry();
    enter(16'h1234);
    idle(1);
    chk("post_lockout_unlock", unlocked, 1);

    // code change with ignored cancel/lock
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    chk("program_shiftb", shift_b, 1);
    chk("program_unlocked", unlocked, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    chk("program_cancel_ignored", shift_b, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h7);
    chk("program_digits", digit_count, 3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h8);
    chk("program_done", shift_b, 0);
    chk("program_clear", reset_a, 1);
    wait_entry();
    enter(16'h1234);
    idle(1);
    chk("old_code_fails", fail_count, 1);
    wait_entry();
    enter(16'h5678);
    idle(1);
    chk("new_code_unlocks", unlocked, 1);
    chk("new_code_fail_clr", fail_count, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

    // cancel racing a validate
    wait_entry();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h7);
    chk("cancel_clear", reset_a, 1);
    chk("cancel_digits", digit_count, 0);
    wait_entry();
    enter(16'h5678);
    idle(1);
    chk("after_cancel_unlock", unlocked, 1);

    // asynchronous reset in the middle of OPEN
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_unlocked", unlocked, 0);
    chk("async_reseta", reset_a, 1);
    chk("async_fails", fail_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (m_phase == P_ENTRY && m_digits < 4) begin
        if (r < 60)      d = mB[15-4*m_digits -: 4];
        else if (r < 80) d = mB[4*m_digits +: 4];
        else             d = 4'($urandom_range(0, 15));
      end else begin
        d = 4'($urandom_range(1, 9));
      end
      cycle($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 6, d);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
